spram_bank: RTL
===============

SPRAM_BANK -- requirements
Module: spram_bank

Interface
REQ-001 SHALL have parameter NBANKS, default 2, meaning the number of 64 KiB banks (legal values 1, 2, 4); each bank is a pair of SB_SPRAM256KA (low and high halfword).
REQ-002 SHALL have parameter IDLE_SLEEP, default 1024, meaning the number of idle cycles before a bank enters sleep; 0 disables sleep.
REQ-003 SHALL have parameter WAKE_CYCLES, default 3, meaning the cycles spent in WAKE before a bank accepts access (minimum 1).
REQ-004 SHALL have localparam ADDR_W = 16 + log2(NBANKS), the byte-address width.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-011 req_wdata  input  32  write data.
REQ-012 req_wstrb  input  4  byte write enables; bit n covers req_wdata[8n+7:8n].
REQ-013 rd_data  output  32  read data; meaningful only while rd_valid is high.
REQ-014 rd_valid  output  1  single-cycle pulse marking rd_data valid.

Function
REQ-015 SHALL decode bank = req_addr[ADDR_W-1:16] (bank 0 when NBANKS = 1) and SPRAM word address = req_addr[15:2].
REQ-016 SHALL map write strobes to MASKWREN: wstrb[0] -> low[1:0], wstrb[1] -> low[3:2], wstrb[2] -> high[1:0], wstrb[3] -> high[3:2].
REQ-017 SHALL assert WREN only on the addressed bank, and only for an accepted write; a write with wstrb = 0 is accepted and leaves memory unchanged.
REQ-018 SHALL keep one FSM per bank with states ACTIVE, SLEEP and WAKE, and SHALL drive the bank's SLEEP pin high only in SLEEP.
REQ-019 ACTIVE: the idle counter SHALL clear on any accepted access to the bank and otherwise increment, saturating; when it reaches IDLE_SLEEP (IDLE_SLEEP > 0) the bank SHALL go to SLEEP on the next edge.
REQ-020 SLEEP: on req_valid addressing the bank, SHALL go to WAKE and load the wake counter with WAKE_CYCLES.
REQ-021 WAKE: SHALL decrement the wake counter each cycle, go to ACTIVE when it reaches 0, and clear the idle counter.
REQ-022 req_ready SHALL be combinational: high if and only if the addressed bank is ACTIVE; a request to a SLEEP or WAKE bank stalls.
REQ-023 The requester SHALL hold req_* stable while req_valid is high and req_ready is low; the block does not register stalled requests.
REQ-024 An accepted read SHALL produce rd_valid = 1 exactly one cycle later, with rd_data taken from the bank captured in a bank-select register at acceptance.
REQ-025 Back-to-back reads to different banks SHALL each return correct data with one-cycle latency and no bubble.
REQ-026 An accepted write SHALL not pulse rd_valid.
REQ-027 Banks not addressed SHALL continue their own idle counting independently; acceptance to one bank SHALL not affect another bank's FSM.
REQ-028 Counters SHALL be sized clog2(IDLE_SLEEP+1) and clog2(WAKE_CYCLES+1) bits; no wrap past saturation.
REQ-029 STANDBY SHALL be tied 0 and POWEROFF tied 1 (powered) on all SPRAMs; CHIPSELECT SHALL be 1.

Reset
REQ-030 While rst_n = 0: all banks ACTIVE, idle and wake counters 0, bank-select 0, rd_valid 0; req_ready follows REQ-022 (high).
REQ-031 Reset asserted during WAKE or SLEEP SHALL return the bank to ACTIVE immediately; SPRAM contents are not cleared by reset.
REQ-032 A read accepted in the cycle reset asserts SHALL NOT produce rd_valid.

Verification
REQ-033 NBANKS=2: write 0xDEADBEEF with wstrb=0xF to 0x00010 -> read 0x00010 returns 0xDEADBEEF with rd_valid exactly 1 cycle after acceptance.
REQ-034 Write 0x11223344 with wstrb=0x5 over 0xAABBCCDD at 0x00020 -> read returns 0xAA22CC44.
REQ-035 Alternate reads of 0x00004 (bank 0) and 0x10004 (bank 1) on consecutive cycles -> rd_valid high every cycle; data alternates correctly.
REQ-036 IDLE_SLEEP=8, WAKE_CYCLES=3: no access to bank 1 for 8 cycles -> bank 1 SLEEP pin high; read to bank 1 -> req_ready low for 4 cycles (1 SLEEP + 3 WAKE), then accepted; data preserved.
REQ-037 Assert rst_n=0 mid-WAKE -> bank ACTIVE, rd_valid 0, req_ready high on the first cycle after release.

Source files
------------

// File: rtl/spram_bank.sv
// Banked single-port RAM built from pairs of 16-bit SPRAM halves, with a per-bank
// sleep/wake power FSM. Each bank is 64 KiB (16K x 32 bits) split into a low and a
// high halfword SPRAM. Requests to a sleeping or waking bank stall via req_ready.
//
// The SPRAM halves are modelled behaviourally at pin level (ADDRESS, DATAIN, MASKWREN,
// WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF, DATAOUT) so the block simulates without
// vendor primitives; each half maps one-to-one onto an SB_SPRAM256KA.
module spram_bank #(
    parameter int unsigned NBANKS      = 2,
    parameter int unsigned IDLE_SLEEP  = 1024,
    parameter int unsigned WAKE_CYCLES = 3,
    localparam int unsigned ADDR_W     = 16 + $clog2(NBANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic [31:0]       rd_data,
    output logic              rd_valid
);

    localparam int unsigned BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int unsigned IDLE_W = (IDLE_SLEEP > 0) ? $clog2(IDLE_SLEEP + 1) : 1;
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam bit          SLEEP_EN = (IDLE_SLEEP > 0);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_SLEEP);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES);

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StSleep  = 2'd1,
        StWake   = 2'd2
    } bank_state_e;

    // Request decode
    logic [BANK_W-1:0] req_bank;
    logic [13:0]       word_addr;
    logic              accept;
    logic              unused_addr_lsbs;

    // Per-bank status and read data, gathered from the bank generate loop
    logic [NBANKS-1:0] bank_active;
    logic [NBANKS-1:0] bank_sleep;
    logic [31:0]       bank_dout [NBANKS];

    // Read return pipeline
    logic              rd_valid_q;
    logic [BANK_W-1:0] bank_sel_q;

    if (NBANKS > 1) begin : g_bank_decode
        assign req_bank = req_addr[ADDR_W-1:16];
    end else begin : g_single_bank
        assign req_bank = '0;
    end

    assign word_addr        = req_addr[15:2];
    assign unused_addr_lsbs = ^req_addr[1:0];
    assign accept           = req_valid & req_ready;

    // Ready is purely a function of the addressed bank's power state
    always_comb begin
        req_ready = bank_active[req_bank];
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic              hit;
        logic              bank_acc;
        bank_state_e       state_q, state_d;
        logic [IDLE_W-1:0] idle_q, idle_d;
        logic [WAKE_W-1:0] wake_q, wake_d;

        // SPRAM pin-level signals shared by both halves
        logic        sp_wren;
        logic        sp_cs;
        logic        sp_standby;
        logic        sp_sleep;
        logic        sp_poweroff;
        logic        sp_enabled;
        logic [3:0]  sp_mask_lo;
        logic [3:0]  sp_mask_hi;
        logic [15:0] mem_lo [16384];
        logic [15:0] mem_hi [16384];
        logic [15:0] dout_lo;
        logic [15:0] dout_hi;

        assign hit      = (req_bank == BANK_W'(b));
        assign bank_acc = accept & hit;

        assign bank_active[b] = (state_q == StActive);
        assign bank_sleep[b]  = (state_q == StSleep);

        // Power FSM and counter registers; reset forces the bank awake
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StActive;
                idle_q  <= '0;
                wake_q  <= '0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
            end
        end

        // Next-state: idle timeout to SLEEP, wake on demand, fixed WAKE delay
        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            unique case (state_q)
                StActive: begin
                    if (bank_acc) begin
                        idle_d = '0;
                    end else begin
                        if (idle_q != IDLE_MAX) begin
                            idle_d = idle_q + 1'b1;
                        end
                        if (SLEEP_EN && (idle_q == IDLE_MAX)) begin
                            state_d = StSleep;
                            idle_d  = '0;
                        end
                    end
                end
                StSleep: begin
                    if (req_valid && hit) begin
                        state_d = StWake;
                        wake_d  = WAKE_LOAD;
                    end
                end
                StWake: begin
                    // The count loaded on entry is the number of cycles spent here
                    if (wake_q <= WAKE_W'(1)) begin
                        state_d = StActive;
                        wake_d  = '0;
                        idle_d  = '0;
                    end else begin
                        wake_d = wake_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StActive;
                    idle_d  = '0;
                    wake_d  = '0;
                end
            endcase
        end

        assign sp_wren     = bank_acc & req_we;
        assign sp_cs       = 1'b1;
        assign sp_standby  = 1'b0;
        assign sp_poweroff = 1'b1;
        assign sp_sleep    = bank_sleep[b];
        assign sp_enabled  = sp_cs & ~sp_standby & ~sp_sleep & sp_poweroff;
        assign sp_mask_lo  = {req_wstrb[1], req_wstrb[1], req_wstrb[0], req_wstrb[0]};
        assign sp_mask_hi  = {req_wstrb[3], req_wstrb[3], req_wstrb[2], req_wstrb[2]};

        // SPRAM halves: nibble-masked write, registered read when not writing
        always_ff @(posedge clk) begin
            if (sp_enabled) begin
                if (sp_wren) begin
                    for (int n = 0; n < 4; n++) begin
                        if (sp_mask_lo[n]) begin
                            mem_lo[word_addr][4*n +: 4] <= req_wdata[4*n +: 4];
                        end
                        if (sp_mask_hi[n]) begin
                            mem_hi[word_addr][4*n +: 4] <= req_wdata[16 + 4*n +: 4];
                        end
                    end
                end else begin
                    dout_lo <= mem_lo[word_addr];
                    dout_hi <= mem_hi[word_addr];
                end
            end else begin
                dout_lo <= '0;
                dout_hi <= '0;
            end
        end

        assign bank_dout[b] = {dout_hi, dout_lo};
    end

    // Remember which bank an accepted read targeted so its data can be picked next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            bank_sel_q <= '0;
        end else begin
            rd_valid_q <= accept & ~req_we;
            if (accept && !req_we) begin
                bank_sel_q <= req_bank;
            end
        end
    end

    // Read data steering from the captured bank
    always_comb begin
        rd_data = bank_dout[bank_sel_q];
    end

    assign rd_valid = rd_valid_q;

endmodule
